// File: rtl/regs_access_arbiter_pkg.sv
// ============================================================================
// Module  : regs_arb_pkg
// Brief   : Shared widths, defaults and FSM state encoding for the register
//           access arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regs_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] OOR_RDATA_DEF = 32'hAAAA_5555;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/regs_access_arbiter_if.sv
// ============================================================================
// Module  : regs_access_arbiter_if
// Brief   : Requester-side and register-block-side signals of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regs_access_arbiter_if
  import regs_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_wr_i;
  logic [ADDR_W*NUM_REQ-1:0] req_addr_i;
  logic [DATA_W*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic                      rsp_err_o;
  logic                      ram_wr_en_o;
  logic [ADDR_W-1:0]         ram_wr_addr_o;
  logic [DATA_W-1:0]         ram_wr_data_o;
  logic                      ram_rd_en_o;
  logic [ADDR_W-1:0]         ram_rd_addr_o;
  logic [DATA_W-1:0]         ram_rd_data_i;
  logic                      busy_o;

  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, req_wdata_i, ram_rd_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o,
    output ram_rd_en_o, ram_rd_addr_o, busy_o
  );

  modport master (
    output req_valid_i, req_wr_i, req_addr_i, req_wdata_i, ram_rd_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o,
    input  ram_rd_en_o, ram_rd_addr_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/regs_access_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first requester at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   cand_sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr + i folded back into 0..NUM_REQ-1
      cand_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand_sum >= NUM_W) begin
        cand_sum = cand_sum - NUM_W;
      end
      cand = cand_sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regs_access_arbiter.sv
// ============================================================================
// Module  : regs_access_arbiter
// Brief   : Serialises NUM_REQ requesters onto one register-block port with
//           round-robin fairness; all bus-facing outputs are registered.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_access_arbiter
  import regs_arb_pkg::*;
#(
  parameter int                NUM_REQ   = 2,
  parameter int                REG_NUM   = 48,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] OOR_RDATA = OOR_RDATA_DEF
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  regs_access_arbiter_if.slave  bus
);

  localparam int              IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(REG_NUM);
  localparam logic [1:0]      WAIT_LOAD = 2'(RD_LAT);

  state_t               state;
  state_t               state_nx;
  logic [IDX_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 any_req;
  logic [IDX_W-1:0]     cur_idx;
  logic [NUM_REQ-1:0]   cur_oh;
  logic                 cur_wr;
  logic [ADDR_W-1:0]    cur_addr;
  logic [DATA_W-1:0]    cur_wdata;
  logic                 in_range;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;
  logic [1:0]           wait_cnt;
  logic [NUM_REQ-1:0]   ready_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic                 rsp_err_q;
  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic                 rd_en_q;
  logic [ADDR_W-1:0]    rd_addr_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid_i),
    .ptr   (ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (any_req)
  );

  assign in_range = ({1'b0, cur_addr} < REG_LIMIT);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (any_req) state_nx = ST_GRANT;
      ST_GRANT:   state_nx = (cur_wr || !in_range) ? ST_RESP : ST_RD_WAIT;
      ST_RD_WAIT: if (wait_cnt == 2'd0) state_nx = ST_RESP;
      ST_RESP:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered off the current state, so each bus event lands
  // one cycle after the state that decides it.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ptr         <= '0;
      cur_idx     <= '0;
      cur_oh      <= '0;
      cur_wr      <= 1'b0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      wait_cnt    <= '0;
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cur_idx   <= gnt_idx;
            cur_oh    <= gnt_oh;
            cur_wr    <= bus.req_wr_i[gnt_idx];
            cur_addr  <= bus.req_addr_i[{gnt_idx, 3'b000} +: ADDR_W];
            cur_wdata <= bus.req_wdata_i[{gnt_idx, 5'b00000} +: DATA_W];
          end
        end
        ST_GRANT: begin
          ready_q <= cur_oh;
          err_q   <= !in_range;
          rdata_q <= '0;
          if (cur_wr) begin
            if (in_range) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= cur_wdata;
            end
          end else if (in_range) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= cur_addr;
            wait_cnt  <= WAIT_LOAD;
          end else begin
            rdata_q <= OOR_RDATA;
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rdata_q <= bus.ram_rd_data_i;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= cur_oh;
          rsp_rdata_q <= rdata_q;
          rsp_err_q   <= err_q;
          ptr         <= (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o   = ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.ram_wr_en_o   = wr_en_q;
  assign bus.ram_wr_addr_o = wr_addr_q;
  assign bus.ram_wr_data_o = wr_data_q;
  assign bus.ram_rd_en_o   = rd_en_q;
  assign bus.ram_rd_addr_o = rd_addr_q;
  assign bus.busy_o        = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_regs_access_arbiter.sv
// ============================================================================
// Module  : tb_regs_access_arbiter
// Brief   : Scoreboard bench: per-requester command queues, RD_LAT=1 memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regs_access_arbiter;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  wr;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [1:0]  taken;
  logic [31:0] rd_data;
  logic [31:0] mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  cmd_t        cmd_q0[$];
  cmd_t        cmd_q1[$];
  int          iss_q0[$];
  int          iss_q1[$];
  exp_t        exp_q[$];

  regs_access_arbiter_if #(.NUM_REQ(2)) bus ();

  regs_access_arbiter #(
    .NUM_REQ   (2),
    .REG_NUM   (48),
    .RD_LAT    (1),
    .OOR_RDATA (32'hAAAA_5555)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus       (bus)
  );

  assign bus.req_valid_i   = valid;
  assign bus.req_wr_i      = wr;
  assign bus.req_addr_i    = addr;
  assign bus.req_wdata_i   = wdata;
  assign bus.ram_rd_data_i = rd_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register block model with one cycle of read latency
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.ram_wr_en_o) mem[bus.ram_wr_addr_o] <= bus.ram_wr_data_o;
    if (bus.ram_rd_en_o) rd_data <= mem[bus.ram_rd_addr_o];
  end

  always @(negedge clk) begin
    if (bus.ram_wr_en_o) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.ram_wr_addr_o;
      last_wr_data <= bus.ram_wr_data_o;
    end
    if (bus.ram_rd_en_o) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_cmd(input int r, input bit w, input logic [7:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = w; c.addr = a; c.wdata = d;
    if (r == 0) cmd_q0.push_back(c);
    else        cmd_q1.push_back(c);
  endtask

  task automatic push_exp(input int r, input logic [31:0] rd, input logic e, input int lat);
    exp_t x;
    x.idx = r; x.rdata = rd; x.err = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (cmd_q0.size() == 0) && (cmd_q1.size() == 0) && (valid == 2'b00) &&
             (exp_q.size() == 0) && !bus.busy_o;
    end
    if (!done) begin
      chk({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Requester driver: holds valid until the ready pulse, then loads the next command
  initial begin
    cmd_t c;
    valid = 2'b00; wr = 2'b00; addr = '0; wdata = '0; taken = 2'b00;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) if (valid[r] && bus.req_ready_o[r]) taken[r] = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) if (taken[r]) begin valid[r] = 1'b0; taken[r] = 1'b0; end
      if (!rst && !valid[0] && cmd_q0.size() > 0) begin
        c = cmd_q0.pop_front();
        valid[0] = 1'b1; wr[0] = c.wr; addr[7:0] = c.addr; wdata[31:0] = c.wdata;
        iss_q0.push_back(cyc);
      end
      if (!rst && !valid[1] && cmd_q1.size() > 0) begin
        c = cmd_q1.pop_front();
        valid[1] = 1'b1; wr[1] = c.wr; addr[15:8] = c.addr; wdata[63:32] = c.wdata;
        iss_q1.push_back(cyc);
      end
    end
  end

  // Response monitor
  exp_t mon_e;
  int   mon_iss;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_iss = -1;
          if (mon_e.idx == 0) begin
            if (iss_q0.size() > 0) mon_iss = iss_q0.pop_front();
          end else begin
            if (iss_q1.size() > 0) mon_iss = iss_q1.pop_front();
          end
          chk("rsp_valid_onehot", 64'(bus.rsp_valid_o), 64'(1) << mon_e.idx);
          chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(mon_e.rdata));
          chk("rsp_err", 64'(bus.rsp_err_o), 64'(mon_e.err));
          if (mon_e.lat >= 0) chk("rsp_latency", 64'(cyc - mon_iss), 64'(mon_e.lat));
        end
      end else begin
        chk("idle_rsp_zero", {31'b0, bus.rsp_err_o, bus.rsp_rdata_o}, 64'd0);
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},  64'(bus.busy_o), 64'd0);
    chk({name, "_ready"}, 64'(bus.req_ready_o), 64'd0);
    chk({name, "_rspv"},  64'(bus.rsp_valid_o), 64'd0);
    chk({name, "_ram"},   {bus.ram_wr_en_o, bus.ram_rd_en_o, bus.ram_wr_addr_o,
                           bus.ram_rd_addr_o, bus.ram_wr_data_o}, 64'd0);
  endtask

  initial begin
    int wc, rc;
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Single write from requester 0
    wc = wr_cnt;
    push_exp(0, 32'h0, 1'b0, 3);
    push_cmd(0, 1'b1, 8'h02, 32'h1234_5678);
    wait_done("t1");
    chk("t1_wr_strobes", 64'(wr_cnt - wc), 64'd1);
    chk("t1_wr_addr", 64'(last_wr_addr), 64'h02);
    chk("t1_wr_data", 64'(last_wr_data), 64'h1234_5678);

    // Read back from requester 1
    rc = rd_cnt;
    push_exp(1, 32'h1234_5678, 1'b0, 5);
    push_cmd(1, 1'b0, 8'h02, 32'h0);
    wait_done("t2");
    chk("t2_rd_strobes", 64'(rd_cnt - rc), 64'd1);

    // Both requesters held busy: strict alternation starting with 0
    wc = wr_cnt; rc = rd_cnt;
    for (int k = 0; k < 4; k++) begin
      push_cmd(0, 1'b1, 8'h10 + 8'(k), 32'hA000_0000 + 32'(k));
      push_cmd(1, 1'b0, 8'h10 + 8'(k), 32'h0);
      push_exp(0, 32'h0, 1'b0, -1);
      push_exp(1, 32'hA000_0000 + 32'(k), 1'b0, -1);
    end
    wait_done("t3");
    chk("t3_wr_strobes", 64'(wr_cnt - wc), 64'd4);
    chk("t3_rd_strobes", 64'(rd_cnt - rc), 64'd4);

    // Out-of-range read and write
    rc = rd_cnt;
    push_exp(0, 32'hAAAA_5555, 1'b1, 3);
    push_cmd(0, 1'b0, 8'h30, 32'h0);
    wait_done("t4");
    chk("t4_no_rd_strobe", 64'(rd_cnt - rc), 64'd0);
    wc = wr_cnt;
    push_exp(1, 32'h0, 1'b1, 3);
    push_cmd(1, 1'b1, 8'h40, 32'hDEAD_BEEF);
    wait_done("t5");
    chk("t5_no_wr_strobe", 64'(wr_cnt - wc), 64'd0);

    // Lone requester served back to back
    push_exp(0, 32'hA000_0001, 1'b0, 5);
    push_exp(0, 32'hA000_0003, 1'b0, -1);
    push_cmd(0, 1'b0, 8'h11, 32'h0);
    push_cmd(0, 1'b0, 8'h13, 32'h0);
    wait_done("t6");

    // Reset while a read is waiting on the register block
    push_cmd(0, 1'b0, 8'h12, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.req_ready_o[0];
    end
    chk("t7_ready_seen", 64'(seen), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("t7_after_reset");
    iss_q0.delete();
    repeat (8) @(negedge clk);

    // Pointer back at 0: requester 0 wins a simultaneous pair
    push_exp(0, 32'h0, 1'b0, 3);
    push_exp(1, 32'h5555_0014, 1'b0, -1);
    push_cmd(0, 1'b1, 8'h14, 32'h5555_0014);
    push_cmd(1, 1'b0, 8'h14, 32'h0);
    wait_done("t8");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
